// File: rtl/lin_cks_seq_if.sv
// Descriptor, byte-stream handshake and result signals of the LIN checksum sequencer.
// master = frame controller / byte framer side, slave = lin_cks_seq.
interface lin_cks_seq_if;
  logic       start;
  logic [7:0] pid;
  logic [3:0] dlen;
  logic       enhanced;
  logic       rx;
  logic       abort;
  logic       byte_vld;
  logic [7:0] byte_in;
  logic       byte_rdy;
  logic       busy;
  logic       cks_vld;
  logic [7:0] cks_out;
  logic       cks_ok;
  logic       err_len;

  modport master (
    output start, pid, dlen, enhanced, rx, abort, byte_vld, byte_in,
    input  byte_rdy, busy, cks_vld, cks_out, cks_ok, err_len
  );

  modport slave (
    input  start, pid, dlen, enhanced, rx, abort, byte_vld, byte_in,
    output byte_rdy, busy, cks_vld, cks_out, cks_ok, err_len
  );
endinterface

// File: rtl/lin_cks_seq.sv
// LIN frame checksum sequencer: end-around-carry sum of PID/data, TX generate or RX check.
// Optional macro LIN_CKS_PID_FILTER_EN forces classic checksum for diagnostic IDs 0x3C/0x3D.
module lin_cks_seq #(
  parameter int unsigned MAX_DLEN = 8
) (
  input  logic          clk,
  input  logic          reset,
  lin_cks_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DATA, CKS, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] dlen_q, dlen_d;
  logic       rx_q, rx_d;
  logic [7:0] cks_out_q, cks_out_d;
  logic       cks_ok_q, cks_ok_d;
  logic       cks_vld_q, cks_vld_d;
  logic       err_len_q, err_len_d;
  logic       byte_rdy_q, byte_rdy_d;
  logic       busy_q, busy_d;

  logic       enhanced_eff;
  logic       dlen_legal;
  logic       accept;
  logic [8:0] sum;
  logic [7:0] acc_add;
  logic [3:0] cnt_inc;

`ifdef LIN_CKS_PID_FILTER_EN
  assign enhanced_eff = bus.enhanced &
                        ~((bus.pid[5:0] == 6'h3C) | (bus.pid[5:0] == 6'h3D));
`else
  assign enhanced_eff = bus.enhanced;
`endif

  assign dlen_legal = (bus.dlen != 4'd0) && (32'(bus.dlen) <= MAX_DLEN);
  assign accept     = bus.byte_vld & byte_rdy_q;
  assign sum        = {1'b0, acc_q} + {1'b0, bus.byte_in};
  // Carry folds back in; cannot overflow again since s[8]=1 implies s[7:0] <= 0xFE.
  assign acc_add    = sum[7:0] + {7'd0, sum[8]};
  assign cnt_inc    = cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dlen_d    = dlen_q;
    rx_d      = rx_q;
    cks_out_d = cks_out_q;
    cks_ok_d  = cks_ok_q;
    err_len_d = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (dlen_legal) begin
              acc_d    = enhanced_eff ? bus.pid : 8'h00;
              cnt_d    = '0;
              dlen_d   = bus.dlen;
              rx_d     = bus.rx;
              cks_ok_d = 1'b0;
              state_d  = DATA;
            end else begin
              err_len_d = 1'b1;
            end
          end
        end
        DATA: begin
          if (accept) begin
            acc_d = acc_add;
            cnt_d = cnt_inc;
            if (cnt_inc == dlen_q) begin
              if (rx_q) begin
                state_d = CKS;
              end else begin
                cks_out_d = ~acc_add;
                state_d   = DONE;
              end
            end
          end
        end
        CKS: begin
          if (accept) begin
            cks_out_d = ~acc_q;
            cks_ok_d  = (bus.byte_in == ~acc_q);
            state_d   = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    cks_vld_d  = (state_d == DONE);
    byte_rdy_d = (state_d == DATA) || (state_d == CKS);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      dlen_q     <= '0;
      rx_q       <= 1'b0;
      cks_out_q  <= '0;
      cks_ok_q   <= 1'b0;
      cks_vld_q  <= 1'b0;
      err_len_q  <= 1'b0;
      byte_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dlen_q     <= dlen_d;
      rx_q       <= rx_d;
      cks_out_q  <= cks_out_d;
      cks_ok_q   <= cks_ok_d;
      cks_vld_q  <= cks_vld_d;
      err_len_q  <= err_len_d;
      byte_rdy_q <= byte_rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.byte_rdy = byte_rdy_q;
  assign bus.busy     = busy_q;
  assign bus.cks_vld  = cks_vld_q;
  assign bus.cks_out  = cks_out_q;
  assign bus.cks_ok   = cks_ok_q;
  assign bus.err_len  = err_len_q;

endmodule

// File: tb/tb_lin_cks_seq.sv
// Directed self-checking bench for lin_cks_seq with hand-computed checksums.
module tb_lin_cks_seq;

  logic clk = 1'b0;
  logic reset;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0] exp_diag;

  always #5 clk = ~clk;

  lin_cks_seq_if bus ();

  lin_cks_seq #(.MAX_DLEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] p, input logic [3:0] d,
                             input logic e, input logic r);
    bus.start = 1'b1; bus.pid = p; bus.dlen = d; bus.enhanced = e; bus.rx = r;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_vld = 1'b1;
    bus.byte_in  = b;
    step();
    bus.byte_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.pid = '0; bus.dlen = '0; bus.enhanced = 1'b0;
    bus.rx = 1'b0; bus.abort = 1'b0; bus.byte_vld = 1'b0; bus.byte_in = '0;
    step(); step();
    check("rst_byte_rdy", 8'(bus.byte_rdy), 8'h0);
    check("rst_busy",     8'(bus.busy),     8'h0);
    check("rst_cks_vld",  8'(bus.cks_vld),  8'h0);
    check("rst_cks_out",  bus.cks_out,      8'h00);
    check("rst_cks_ok",   8'(bus.cks_ok),   8'h0);
    check("rst_err_len",  8'(bus.err_len),  8'h0);
    reset = 1'b0;
    step();

    // TX enhanced pid 0x4A: 4A+55+93+E5 with carry wrap -> 0x19, inverted 0xE6
    start_frame(8'h4A, 4'd3, 1'b1, 1'b0);
    check("tx_busy_t1",  8'(bus.busy),     8'h1);
    check("tx_rdy_t1",   8'(bus.byte_rdy), 8'h1);
    send(8'h55); send(8'h93); send(8'hE5);
    check("txe_vld",     8'(bus.cks_vld),  8'h1);
    check("txe_cks",     bus.cks_out,      8'hE6);
    check("txe_ok",      8'(bus.cks_ok),   8'h0);
    check("txe_done_busy", 8'(bus.busy),   8'h1);
    step();
    check("txe_vld_pulse", 8'(bus.cks_vld), 8'h0);
    check("txe_busy_n2",   8'(bus.busy),    8'h0);

    // TX classic, same data -> 0x31
    start_frame(8'h4A, 4'd3, 1'b0, 1'b0);
    send(8'h55); send(8'h93); send(8'hE5);
    check("txc_vld", 8'(bus.cks_vld), 8'h1);
    check("txc_cks", bus.cks_out,     8'h31);
    step();

    // Carry wrap: FF+FF -> FF, inverted 00
    start_frame(8'h00, 4'd2, 1'b0, 1'b0);
    send(8'hFF); send(8'hFF);
    check("wrap_vld", 8'(bus.cks_vld), 8'h1);
    check("wrap_cks", bus.cks_out,     8'h00);
    step();

    // RX enhanced with correct checksum
    start_frame(8'h4A, 4'd3, 1'b1, 1'b1);
    send(8'h55); send(8'h93); send(8'hE5);
    check("rx_cks_state_vld", 8'(bus.cks_vld),  8'h0);
    check("rx_cks_state_rdy", 8'(bus.byte_rdy), 8'h1);
    send(8'hE6);
    check("rx_good_vld", 8'(bus.cks_vld), 8'h1);
    check("rx_good_ok",  8'(bus.cks_ok),  8'h1);
    check("rx_good_cks", bus.cks_out,     8'hE6);
    step();
    check("rx_ok_held", 8'(bus.cks_ok), 8'h1);

    // RX enhanced with wrong checksum; start clears cks_ok
    start_frame(8'h4A, 4'd3, 1'b1, 1'b1);
    check("rx_ok_cleared", 8'(bus.cks_ok), 8'h0);
    send(8'h55); send(8'h93); send(8'hE5); send(8'hE7);
    check("rx_bad_vld", 8'(bus.cks_vld), 8'h1);
    check("rx_bad_ok",  8'(bus.cks_ok),  8'h0);
    step();

    // Diagnostic ID 0x3C, enhanced requested
`ifdef LIN_CKS_PID_FILTER_EN
    exp_diag = 8'hFE;
`else
    exp_diag = 8'hC2;
`endif
    start_frame(8'h3C, 4'd1, 1'b1, 1'b0);
    send(8'h01);
    check("diag_vld", 8'(bus.cks_vld), 8'h1);
    check("diag_cks", bus.cks_out,     exp_diag);
    step();

    // Abort after 2 of 4 bytes, with a byte offered on the abort cycle
    start_frame(8'h4A, 4'd4, 1'b1, 1'b0);
    send(8'h10); send(8'h20);
    bus.abort = 1'b1; bus.byte_vld = 1'b1; bus.byte_in = 8'h30;
    step();
    bus.abort = 1'b0; bus.byte_vld = 1'b0;
    check("abort_busy",    8'(bus.busy),     8'h0);
    check("abort_rdy",     8'(bus.byte_rdy), 8'h0);
    check("abort_vld",     8'(bus.cks_vld),  8'h0);
    check("abort_cks_hold", bus.cks_out,     exp_diag);
    step();
    check("abort_vld_late", 8'(bus.cks_vld), 8'h0);
    start_frame(8'h4A, 4'd1, 1'b0, 1'b0);
    send(8'h01);
    check("post_abort_vld", 8'(bus.cks_vld), 8'h1);
    check("post_abort_cks", bus.cks_out,     8'hFE);
    step();

    // Abort together with start in IDLE: start ignored
    bus.abort = 1'b1;
    start_frame(8'h4A, 4'd1, 1'b0, 1'b0);
    bus.abort = 1'b0;
    check("abort_start_busy", 8'(bus.busy), 8'h0);

    // Illegal dlen values
    start_frame(8'h4A, 4'd0, 1'b0, 1'b0);
    check("len0_err",  8'(bus.err_len), 8'h1);
    check("len0_busy", 8'(bus.busy),    8'h0);
    step();
    check("len0_pulse", 8'(bus.err_len), 8'h0);
    start_frame(8'h4A, 4'd9, 1'b0, 1'b0);
    check("len9_err",  8'(bus.err_len), 8'h1);
    check("len9_busy", 8'(bus.busy),    8'h0);
    step();
    check("len9_pulse", 8'(bus.err_len), 8'h0);

    // Largest legal length: eight 0x01 bytes classic -> 0x08, inverted 0xF7
    start_frame(8'h00, 4'd8, 1'b0, 1'b0);
    check("len8_err", 8'(bus.err_len), 8'h0);
    for (int i = 0; i < 8; i++) send(8'h01);
    check("len8_vld", 8'(bus.cks_vld), 8'h1);
    check("len8_cks", bus.cks_out,     8'hF7);
    step();

    // start while in DATA is ignored
    start_frame(8'h00, 4'd2, 1'b0, 1'b0);
    bus.start = 1'b1; bus.dlen = 4'd0;
    send(8'hFF);
    bus.start = 1'b0;
    check("mid_start_err",  8'(bus.err_len), 8'h0);
    check("mid_start_busy", 8'(bus.busy),    8'h1);
    send(8'hFF);
    check("mid_start_vld", 8'(bus.cks_vld), 8'h1);
    check("mid_start_cks", bus.cks_out,     8'h00);
    step();

    // Reset mid-DATA after a frame leaving non-zero cks_out / cks_ok
    start_frame(8'h4A, 4'd1, 1'b1, 1'b1);
    send(8'h01); send(8'hB4);
    check("pre_rst_ok", 8'(bus.cks_ok), 8'h1);
    step();
    start_frame(8'h4A, 4'd3, 1'b1, 1'b0);
    send(8'h55);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_byte_rdy", 8'(bus.byte_rdy), 8'h0);
    check("mrst_busy",     8'(bus.busy),     8'h0);
    check("mrst_cks_vld",  8'(bus.cks_vld),  8'h0);
    check("mrst_cks_out",  bus.cks_out,      8'h00);
    check("mrst_cks_ok",   8'(bus.cks_ok),   8'h0);
    check("mrst_err_len",  8'(bus.err_len),  8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
